// File: rtl/sha_sigma_pkg.sv
// ---------------------------------------------------------------------------
// sha_sigma_pkg
// Shared definitions for the SHA-2 Sigma/sigma pipeline.
//   sigma_mode_e   : function select carried with each word
//   SIGMA_AMT_32   : rotate/shift amounts for the SHA-256 functions
//   SIGMA_AMT_64   : rotate/shift amounts for the SHA-512 functions
//   sigma_amount() : picks an amount from the table matching a word width
//   is_shift_term(): true for the term that is a logical shift, not a rotate
// Table rows follow sigma_mode_e order; columns are term 0, 1, 2.
// ---------------------------------------------------------------------------
package sha_sigma_pkg;

    typedef enum logic [1:0] {
        SIG0_BIG   = 2'd0,
        SIG1_BIG   = 2'd1,
        SIG0_SMALL = 2'd2,
        SIG1_SMALL = 2'd3
    } sigma_mode_e;

    localparam int SIGMA_AMT_32 [4][3] = '{
        '{ 2, 13, 22},
        '{ 6, 11, 25},
        '{ 7, 18,  3},
        '{17, 19, 10}
    };

    localparam int SIGMA_AMT_64 [4][3] = '{
        '{28, 34, 39},
        '{14, 18, 41},
        '{ 1,  8,  7},
        '{19, 61,  6}
    };

    // Any width other than 64 falls back to the SHA-256 table.
    function automatic int sigma_amount(input int width, input int mode, input int idx);
        if (width == 64) begin
            return SIGMA_AMT_64[mode][idx];
        end
        return SIGMA_AMT_32[mode][idx];
    endfunction

    // The small sigma functions replace their third rotate with a shift.
    function automatic bit is_shift_term(input int mode, input int idx);
        return (mode >= 2) && (idx == 2);
    endfunction

endpackage

// File: rtl/sigma_terms.sv
// ---------------------------------------------------------------------------
// sigma_terms
// Combinational generator of the three terms of the selected SHA-2 Sigma or
// sigma function. The caller XORs the terms together.
// Parameters:
//   WIDTH : word width, 32 (SHA-256) or 64 (SHA-512)
// Ports:
//   mode  : in  function select
//   word  : in  operand word
//   term0 : out first rotated term
//   term1 : out second rotated term
//   term2 : out third term (rotate for Sigma, shift for sigma)
// ---------------------------------------------------------------------------
module sigma_terms
    import sha_sigma_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  sigma_mode_e      mode,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] term0,
    output logic [WIDTH-1:0] term1,
    output logic [WIDTH-1:0] term2
);

    logic [WIDTH-1:0] cand [4][3];

    // All amounts are elaboration-time constants, so every candidate term is
    // just wiring; the mode only drives the final multiplexer.
    for (genvar m = 0; m < 4; m++) begin : g_mode
        for (genvar i = 0; i < 3; i++) begin : g_term
            localparam int AMT = sigma_amount(WIDTH, m, i);
            if (is_shift_term(m, i)) begin : g_shr
                assign cand[m][i] = word >> AMT;
            end else begin : g_rotr
                assign cand[m][i] = {word[AMT-1:0], word[WIDTH-1:AMT]};
            end
        end
    end

    always_comb begin
        term0 = cand[mode][0];
        term1 = cand[mode][1];
        term2 = cand[mode][2];
    end

endmodule

// File: rtl/sigma_pipe.sv
// ---------------------------------------------------------------------------
// sigma_pipe
// Two-stage valid/ready pipeline computing SHA-2 Sigma0/Sigma1/sigma0/sigma1.
// S1 holds the three mode-resolved terms and the tag, S2 holds their XOR and
// the tag. Results leave in acceptance order, one per cycle when unstalled.
// Parameters:
//   WIDTH : word width, 32 (SHA-256) or 64 (SHA-512)
//   TAG_W : width of the sideband tag returned with each result
// Ports:
//   clk       : in  clock, rising edge
//   reset     : in  synchronous active-high reset
//   in_valid  : in  input word present
//   in_ready  : out input word accepted this cycle
//   in_mode   : in  0=Sigma0 1=Sigma1 2=sigma0 3=sigma1
//   in_data   : in  operand word
//   in_tag    : in  sideband tag
//   out_valid : out result present
//   out_ready : in  consumer takes the result
//   out_data  : out result word, zero when out_valid is low
//   out_tag   : out result tag, zero when out_valid is low
// ---------------------------------------------------------------------------
module sigma_pipe
    import sha_sigma_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [WIDTH-1:0] term0;
    logic [WIDTH-1:0] term1;
    logic [WIDTH-1:0] term2;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_term0;
    logic [WIDTH-1:0] s1_term1;
    logic [WIDTH-1:0] s1_term2;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic [TAG_W-1:0] s2_tag;

    logic             s1_adv;
    logic             s2_adv;

    sigma_terms #(
        .WIDTH (WIDTH)
    ) u_terms (
        .mode  (sigma_mode_e'(in_mode)),
        .word  (in_data),
        .term0 (term0),
        .term1 (term1),
        .term2 (term2)
    );

    // A stage moves when it is empty or the stage after it is moving, so the
    // stall from out_ready ripples back to in_ready in the same cycle.
    // in_ready is forced high in reset; anything taken then is cleared by
    // the reset itself.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = reset || s1_adv;
    end

    // Stage 1: capture the mode-resolved terms, so a later mode change never
    // affects a word already accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_term0 <= '0;
            s1_term1 <= '0;
            s1_term2 <= '0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            s1_term0 <= term0;
            s1_term1 <= term1;
            s1_term2 <= term2;
            s1_tag   <= in_tag;
        end
    end

    // Stage 2: fold the terms into the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            s2_data  <= s1_term0 ^ s1_term1 ^ s1_term2;
            s2_tag   <= s1_tag;
        end
    end

    // Outputs are masked to zero when idle and during reset, so nothing stale
    // is visible before the registers have cleared.
    always_comb begin
        out_valid = s2_valid && !reset;
        out_data  = out_valid ? s2_data : '0;
        out_tag   = out_valid ? s2_tag  : '0;
    end

endmodule

// File: tb/tb_sigma_pipe.sv
// ---------------------------------------------------------------------------
// tb_sigma_pipe
// Self-checking bench for sigma_pipe. A 32-bit instance is exercised with a
// scoreboard queue filled at acceptance and drained at output; a 64-bit
// instance is checked against known vectors and a reference model.
// ---------------------------------------------------------------------------
module tb_sigma_pipe;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_data;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [1:0]  w_in_mode;
    logic [63:0] w_in_data;
    logic [3:0]  w_in_tag;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_out_data;
    logic [3:0]  w_out_tag;

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t q[$];

    logic        s_acc;
    logic        s_fire;
    logic        s_ir;
    logic        s_ov;
    logic [31:0] s_od;
    logic [3:0]  s_ot;

    sigma_pipe #(
        .WIDTH (32),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    sigma_pipe #(
        .WIDTH (64),
        .TAG_W (4)
    ) dut64 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_mode   (w_in_mode),
        .in_data   (w_in_data),
        .in_tag    (w_in_tag),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data),
        .out_tag   (w_out_tag)
    );

    always #5 clk = ~clk;

    // Reference rotate on a w-bit value held in the low bits of x.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    // Reference SHA-2 Sigma/sigma functions.
    function automatic logic [63:0] sigma_model(input int w, input logic [1:0] mode,
                                                input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        if (w == 32) begin
            case (mode)
                2'd0: r = rotr(x, 2, 32)  ^ rotr(x, 13, 32) ^ rotr(x, 22, 32);
                2'd1: r = rotr(x, 6, 32)  ^ rotr(x, 11, 32) ^ rotr(x, 25, 32);
                2'd2: r = rotr(x, 7, 32)  ^ rotr(x, 18, 32) ^ (x >> 3);
                default: r = rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
            endcase
        end else begin
            case (mode)
                2'd0: r = rotr(x, 28, 64) ^ rotr(x, 34, 64) ^ rotr(x, 39, 64);
                2'd1: r = rotr(x, 14, 64) ^ rotr(x, 18, 64) ^ rotr(x, 41, 64);
                2'd2: r = rotr(x, 1, 64)  ^ rotr(x, 8, 64)  ^ (x >> 7);
                default: r = rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
            endcase
        end
        return r;
    endfunction

    // Samples the 32-bit DUT mid-cycle, records the expected result of any
    // word accepted at the coming edge, then advances to just after the edge.
    task automatic step();
        logic [63:0] r;
        exp_t        e;
        @(negedge clk);
        s_ir   = in_ready;
        s_ov   = out_valid;
        s_od   = out_data;
        s_ot   = out_tag;
        s_acc  = in_valid && in_ready && !reset;
        s_fire = out_valid && out_ready && !reset;
        if (reset) begin
            q.delete();
        end else if (s_acc) begin
            r = sigma_model(32, in_mode, {32'h0, in_data});
            e.data = r[31:0];
            e.tag  = in_tag;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] m,
                                 input logic [31:0] d, input logic [3:0] t);
        in_valid = v;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b1, 2'd0, 32'hDEAD_BEEF, 4'hA);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (s_ir !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset_in_ready: got %b, expected 1", s_ir);
            end
            tests_run++;
            if (s_ov !== 1'b0 || s_od !== 32'h0 || s_ot !== 4'h0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs: got valid=%b data=%h tag=%h, expected 0/0/0",
                         s_ov, s_od, s_ot);
            end
        end
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
    endtask

    task automatic test_vectors();
        logic [31:0] vec [4];
        vec = '{32'h4008_0400, 32'h0420_0080, 32'h0200_4000, 32'h0000_A000};
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            applyStimulus(1'b1, 2'(m), 32'h0000_0001, 4'(m + 1));
            step();
            tests_run++;
            if (s_acc !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL vec_accept mode %0d: got %b, expected 1", m, s_acc);
            end
            applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
            step();
            tests_run++;
            if (s_ov !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL vec_latency mode %0d: out_valid %b one edge after accept, expected 0",
                         m, s_ov);
            end
            step();
            tests_run++;
            if (s_ov !== 1'b1 || s_od !== vec[m] || s_ot !== 4'(m + 1)) begin
                tests_failed++;
                $display("[TB] FAIL vec_result mode %0d: got valid=%b data=%h tag=%h, expected 1/%h/%h",
                         m, s_ov, s_od, s_ot, vec[m], 4'(m + 1));
            end
        end
        q.delete();
    endtask

    task automatic test_stream();
        exp_t e;
        int   i     = 0;
        int   outs  = 0;
        int   first = -1;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && outs < 8; k++) begin
            if (i < 8) applyStimulus(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'(i));
            else       applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
            step();
            if (i < 8) begin
                tests_run++;
                if (s_acc !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_accept word %0d: got %b, expected 1", i, s_acc);
                end
            end
            if (s_acc) i++;
            if (s_fire) begin
                if (first < 0) first = k;
                tests_run++;
                if (k != first + outs || s_ot !== 4'(outs)) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_order: got tag %0d at step %0d, expected tag %0d at step %0d",
                             s_ot, k, outs, first + outs);
                end
                e = q.pop_front();
                tests_run++;
                if (s_od !== e.data || s_ot !== e.tag) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_data: got %h/%h, expected %h/%h", s_od, s_ot, e.data, e.tag);
                end
                outs++;
            end
        end
        tests_run++;
        if (outs != 8 || q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d results (%0d pending), expected 8 (0)", outs, q.size());
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [31:0] held_d = '0;
        logic [3:0]  held_t = '0;
        int          i      = 0;
        int          outs   = 0;
        for (int k = 0; k < 60 && outs < 12; k++) begin
            out_ready = !(k >= 6 && k < 11);
            if (i < 12) applyStimulus(1'b1, 2'(i % 4), $urandom, 4'(i));
            else        applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
            step();
            if (s_acc) i++;
            if (k >= 6 && k < 11) begin
                tests_run++;
                if (s_ov !== 1'b1 || s_ir !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_flags step %0d: got out_valid=%b in_ready=%b, expected 1/0",
                             k, s_ov, s_ir);
                end
                if (k == 6) begin
                    held_d = s_od;
                    held_t = s_ot;
                end else begin
                    tests_run++;
                    if (s_od !== held_d || s_ot !== held_t) begin
                        tests_failed++;
                        $display("[TB] FAIL stall_hold step %0d: got %h/%h, expected %h/%h",
                                 k, s_od, s_ot, held_d, held_t);
                    end
                end
            end
            if (s_fire) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_data: got %h/%h, expected no result", s_od, s_ot);
                end else begin
                    e = q.pop_front();
                    if (s_od !== e.data || s_ot !== e.tag) begin
                        tests_failed++;
                        $display("[TB] FAIL bp_data: got %h/%h, expected %h/%h", s_od, s_ot, e.data, e.tag);
                    end
                end
                outs++;
            end
        end
        tests_run++;
        if (outs != 12 || q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_count: got %0d results (%0d pending), expected 12 (0)", outs, q.size());
        end
        out_ready = 1'b1;
        applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'd1, 32'h1234_5678, 4'h3);
        step();
        applyStimulus(1'b1, 2'd2, 32'h9ABC_DEF0, 4'h4);
        step();
        applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
        reset = 1'b1;
        step();
        tests_run++;
        if (s_ov !== 1'b0 || s_od !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL inflight_during_reset: got valid=%b data=%h, expected 0/0", s_ov, s_od);
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            tests_run++;
            if (s_ov !== 1'b0 || s_od !== 32'h0 || s_ot !== 4'h0) begin
                tests_failed++;
                $display("[TB] FAIL inflight_dropped step %0d: got valid=%b data=%h tag=%h, expected 0/0/0",
                         k, s_ov, s_od, s_ot);
            end
        end
    endtask

    task automatic test_idle();
        applyStimulus(1'b0, 2'd3, 32'hFFFF_FFFF, 4'hF);
        for (int k = 0; k < 4; k++) begin
            out_ready = k[0];
            step();
            tests_run++;
            if (s_ov !== 1'b0 || s_od !== 32'h0 || s_ot !== 4'h0) begin
                tests_failed++;
                $display("[TB] FAIL idle_zero step %0d: got valid=%b data=%h tag=%h, expected 0/0/0",
                         k, s_ov, s_od, s_ot);
            end
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   i    = 0;
        int   outs = 0;
        for (int k = 0; k < 200 && outs < 20; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (i < 20 && $urandom_range(0, 4) != 0)
                applyStimulus(1'b1, 2'(i % 4), $urandom, 4'(i));
            else
                applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
            step();
            if (s_acc) i++;
            if (s_fire) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_data: got %h/%h, expected no result", s_od, s_ot);
                end else begin
                    e = q.pop_front();
                    if (s_od !== e.data || s_ot !== e.tag) begin
                        tests_failed++;
                        $display("[TB] FAIL b2b_data: got %h/%h, expected %h/%h", s_od, s_ot, e.data, e.tag);
                    end
                end
                outs++;
            end
        end
        tests_run++;
        if (outs != 20 || q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: got %0d results (%0d pending), expected 20 (0)", outs, q.size());
        end
        out_ready = 1'b1;
        applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
    endtask

    task automatic test_wide();
        logic [63:0] data [2];
        logic [1:0]  mode [2];
        logic [63:0] expv [2];
        int          n;
        data[0] = 64'h1;
        mode[0] = 2'd1;
        expv[0] = 64'h0004_4000_0080_0000;
        data[1] = {$urandom, $urandom};
        mode[1] = 2'd2;
        expv[1] = sigma_model(64, mode[1], data[1]);
        w_out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            w_in_valid = 1'b1;
            w_in_mode  = mode[v];
            w_in_data  = data[v];
            w_in_tag   = 4'(v + 5);
            @(negedge clk);
            tests_run++;
            if (w_in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL wide_accept vec %0d: got %b, expected 1", v, w_in_ready);
            end
            @(posedge clk);
            #1;
            w_in_valid = 1'b0;
            n = 0;
            while (n < 10) begin
                @(negedge clk);
                n++;
                if (w_out_valid) break;
            end
            tests_run++;
            if (w_out_valid !== 1'b1 || n != 2) begin
                tests_failed++;
                $display("[TB] FAIL wide_latency vec %0d: got valid=%b after %0d edges, expected 1 after 2",
                         v, w_out_valid, n);
            end
            tests_run++;
            if (w_out_data !== expv[v] || w_out_tag !== 4'(v + 5)) begin
                tests_failed++;
                $display("[TB] FAIL wide_result vec %0d: got %h/%h, expected %h/%h",
                         v, w_out_data, w_out_tag, expv[v], 4'(v + 5));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_mode     = 2'd0;
        in_data     = 32'h0;
        in_tag      = 4'h0;
        out_ready   = 1'b1;
        w_in_valid  = 1'b0;
        w_in_mode   = 2'd0;
        w_in_data   = 64'h0;
        w_in_tag    = 4'h0;
        w_out_ready = 1'b1;

        test_reset();
        test_vectors();
        test_stream();
        test_backpressure();
        test_reset_inflight();
        test_idle();
        test_back_to_back();
        test_wide();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
